rbm_result_reader: RTL and testbench

Consumer for the RBM core's result side. Captures the packed classifier output vector on the rising edge of `finish`, finds the winning class by signed argmax, and streams each score out one element per handshake. The class index is held until the next capture. Sits between `Main` and the host/readout logic, mirroring the input feeder on the other end of `Main`.

---
 rtl/rbm_result_reader.sv | 159 +++++++++++++++
 tb/tb_rbm_result_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rbm_result_reader.sv
// rbm_result_reader
//   Result-side consumer for the RBM core. On a rising edge of `finish` the packed score
//   vector is snapshotted, a signed argmax is computed one element per cycle, and the scores
//   are then streamed out one element per valid/ready handshake.
//
// Ports
//   clock, reset            single clock, synchronous active-high reset
//   finish                  core-done level; a rising edge starts a capture
//   OutputDataPort          packed scores, element i at [i*bitlength +: bitlength]
//   out_ready               downstream accepts the current element
//   out_valid/out_data/out_index/out_last   score stream
//   class_valid/class_index argmax of the most recent capture
//   busy                    capture, scan or stream in progress
//   overrun                 sticky: a capture edge arrived while busy
module rbm_result_reader #(
   parameter int unsigned output_dim      = 10,
   parameter int unsigned bitlength       = 12,
   parameter int unsigned index_bitlength = 4
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              finish,
   input  logic [output_dim*bitlength-1:0]   OutputDataPort,
   input  logic                              out_ready,
   output logic                              out_valid,
   output logic [bitlength-1:0]              out_data,
   output logic [index_bitlength-1:0]        out_index,
   output logic                              out_last,
   output logic                              class_valid,
   output logic [index_bitlength-1:0]        class_index,
   output logic                              busy,
   output logic                              overrun
);

   typedef enum logic [1:0] {StIdle, StScan, StSend} state_e;

   localparam logic [index_bitlength-1:0] LastIdx = index_bitlength'(output_dim - 1);
   // Index of the element preceding the final compare.
   localparam logic [index_bitlength-1:0] PenIdx  = index_bitlength'(output_dim - 2);
   localparam logic [index_bitlength-1:0] OneIdx  = index_bitlength'(1);

   state_e                       state_q, state_d;
   logic                         finish_d_q, finish_d_d;
   logic [bitlength-1:0]         snap_q [output_dim];
   logic [bitlength-1:0]         snap_d [output_dim];
   logic [index_bitlength-1:0]   idx_q, idx_d;
   logic [bitlength-1:0]         best_val_q, best_val_d;
   logic [index_bitlength-1:0]   best_idx_q, best_idx_d;
   logic [index_bitlength-1:0]   class_index_q, class_index_d;
   logic                         class_valid_q, class_valid_d;
   logic                         overrun_q, overrun_d;

   logic                         capture_evt;
   logic [index_bitlength-1:0]   scan_idx;
   logic [bitlength-1:0]         scan_val;
   logic                         scan_gt;
   logic                         send;

   assign capture_evt = finish & ~finish_d_q;
   // idx holds the last element already folded into best; SCAN compares the next one.
   assign scan_idx    = idx_q + OneIdx;
   assign scan_val    = snap_q[scan_idx];
   assign scan_gt     = $signed(scan_val) > $signed(best_val_q);
   assign send        = (state_q == StSend);

   always_comb begin
      state_d       = state_q;
      finish_d_d    = finish;
      snap_d        = snap_q;
      idx_d         = idx_q;
      best_val_d    = best_val_q;
      best_idx_d    = best_idx_q;
      class_index_d = class_index_q;
      class_valid_d = class_valid_q;
      overrun_d     = overrun_q;

      unique case (state_q)
         StIdle: begin
            if (capture_evt) begin
               for (int i = 0; i < int'(output_dim); i++) begin
                  snap_d[i] = OutputDataPort[i*bitlength +: bitlength];
               end
               idx_d         = '0;
               best_val_d    = OutputDataPort[bitlength-1:0];
               best_idx_d    = '0;
               class_valid_d = 1'b0;
               state_d       = StScan;
            end
         end
         StScan: begin
            // Strict greater-than keeps the lower index on ties.
            if (scan_gt) begin
               best_val_d = scan_val;
               best_idx_d = scan_idx;
            end
            idx_d = scan_idx;
            if (idx_q == PenIdx) begin
               class_index_d = scan_gt ? scan_idx : best_idx_q;
               class_valid_d = 1'b1;
               idx_d         = '0;
               state_d       = StSend;
            end
         end
         StSend: begin
            if (out_ready) begin
               if (idx_q == LastIdx) begin
                  idx_d   = '0;
                  state_d = StIdle;
               end else begin
                  idx_d = idx_q + OneIdx;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // A capture edge while busy is dropped but remembered.
      if (capture_evt && (state_q != StIdle)) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         finish_d_q    <= 1'b0;
         for (int i = 0; i < int'(output_dim); i++) begin
            snap_q[i] <= '0;
         end
         idx_q         <= '0;
         best_val_q    <= '0;
         best_idx_q    <= '0;
         class_index_q <= '0;
         class_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         finish_d_q    <= finish_d_d;
         snap_q        <= snap_d;
         idx_q         <= idx_d;
         best_val_q    <= best_val_d;
         best_idx_q    <= best_idx_d;
         class_index_q <= class_index_d;
         class_valid_q <= class_valid_d;
         overrun_q     <= overrun_d;
      end
   end

   // Stream outputs are forced to zero outside SEND so idle outputs are clean.
   assign out_valid   = send;
   assign out_data    = send ? snap_q[idx_q] : '0;
   assign out_index   = send ? idx_q : '0;
   assign out_last    = send && (idx_q == LastIdx);
   assign class_valid = class_valid_q;
   assign class_index = class_index_q;
   assign busy        = (state_q != StIdle);
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_rbm_result_reader.sv
// Self-checking bench for rbm_result_reader: directed and randomized score vectors checked
// against a simple argmax/stream reference model.
module tb_rbm_result_reader;

   localparam int N  = 10;
   localparam int BW = 12;
   localparam int IW = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic              finish;
   logic [N*BW-1:0]   OutputDataPort;
   logic              out_ready;
   logic              out_valid;
   logic [BW-1:0]     out_data;
   logic [IW-1:0]     out_index;
   logic              out_last;
   logic              class_valid;
   logic [IW-1:0]     class_index;
   logic              busy;
   logic              overrun;

   int n_assert = 0;
   int n_fail   = 0;
   int sc [N];

   always #5 clock = ~clock;

   rbm_result_reader #(
      .output_dim      (N),
      .bitlength       (BW),
      .index_bitlength (IW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .finish         (finish),
      .OutputDataPort (OutputDataPort),
      .out_ready      (out_ready),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_index      (out_index),
      .out_last       (out_last),
      .class_valid    (class_valid),
      .class_index    (class_index),
      .busy           (busy),
      .overrun        (overrun)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: signed argmax, first maximum wins.
   function automatic int model_argmax();
      int best = 0;
      for (int i = 1; i < N; i++) if (sc[i] > sc[best]) best = i;
      return best;
   endfunction

   function automatic logic [BW-1:0] el(input int i);
      int v = sc[i];
      return v[BW-1:0];
   endfunction

   function automatic logic [N*BW-1:0] pack();
      logic [N*BW-1:0] v;
      for (int i = 0; i < N; i++) v[i*BW +: BW] = el(i);
      return v;
   endfunction

   task automatic randomize_scores();
      for (int i = 0; i < N; i++) sc[i] = int'($urandom_range(0, 4095)) - 2048;
   endtask

   // Raise finish, then walk through the scan window checking when results appear.
   task automatic capture();
      logic [N*BW-1:0] v;
      finish = 1'b0;
      step();
      v = pack();
      OutputDataPort = v;
      finish = 1'b1;
      step();
      chk("busy_at_e0", 32'(busy), 32'd1);
      chk("class_valid_cleared", 32'(class_valid), 32'd0);
      // Snapshot must be private from here on.
      OutputDataPort = ~v;
      for (int k = 1; k < N; k++) begin
         if (k == 5) finish = 1'b0;
         chk("valid_early", 32'(out_valid), 32'd0);
         step();
      end
      chk("valid_rise", 32'(out_valid), 32'd1);
      chk("class_valid", 32'(class_valid), 32'd1);
      chk("class_index", 32'(class_index), 32'(model_argmax()));
   endtask

   // mode 0: ready always; 1: ready 1,0,0 repeating; 2: random. poke raises finish mid-stream.
   task automatic stream(input int mode, input bit poke);
      int got = 0;
      int cyc = 0;
      logic pv = 1'b0;
      logic prdy = 1'b0;
      logic [BW-1:0] pd = '0;
      logic [IW-1:0] pi = '0;
      logic rdy;
      while (got < N && cyc < 200) begin
         if (pv && !prdy) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(pd));
            chk("stall_index", 32'(out_index), 32'(pi));
         end
         chk("stream_valid", 32'(out_valid), 32'd1);
         if (out_valid) begin
            chk("data", 32'(out_data), 32'(el(got)));
            chk("index", 32'(out_index), 32'(got));
            chk("last", 32'(out_last), 32'(got == N - 1));
         end
         if (mode == 0) rdy = 1'b1;
         else if (mode == 1) rdy = (cyc % 3 == 0);
         else rdy = 1'($urandom_range(0, 1));
         out_ready = rdy;
         if (poke && cyc == 3) finish = 1'b1;
         if (out_valid && rdy) got++;
         pv = out_valid; pd = out_data; pi = out_index; prdy = rdy;
         step();
         cyc++;
      end
      chk("handshakes", 32'(got), 32'(N));
      if (mode == 0) chk("stream_cycles", 32'(cyc), 32'(N));
      chk("valid_drop", 32'(out_valid), 32'd0);
      chk("busy_drop", 32'(busy), 32'd0);
      out_ready = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_data"}, 32'(out_data), 32'd0);
      chk({tag, "_out_index"}, 32'(out_index), 32'd0);
      chk({tag, "_out_last"}, 32'(out_last), 32'd0);
      chk({tag, "_class_valid"}, 32'(class_valid), 32'd0);
      chk({tag, "_class_index"}, 32'(class_index), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_overrun"}, 32'(overrun), 32'd0);
   endtask

   initial begin
      int waits;
      reset = 1'b1;
      finish = 1'b0;
      out_ready = 1'b0;
      OutputDataPort = '0;
      step();
      step();
      chk_all_zero("reset");
      reset = 1'b0;
      step();

      // Ramp 0,3,...,27 with ready held high.
      for (int i = 0; i < N; i++) sc[i] = i * 3;
      out_ready = 1'b1;
      capture();
      stream(0, 1'b0);

      // All negative, -1 must win under signed compare.
      for (int i = 0, j = 0; i < N; i++) begin
         if (i == 4) sc[i] = -1;
         else begin sc[i] = -2048 + j; j++; end
      end
      capture();
      stream(0, 1'b0);

      // Tie at maximum keeps lower index.
      for (int i = 0; i < N; i++) sc[i] = (i == 2 || i == 7) ? 2047 : 0;
      capture();
      stream(0, 1'b0);

      // Stalling ready pattern.
      randomize_scores();
      capture();
      stream(1, 1'b0);
      chk("no_overrun_yet", 32'(overrun), 32'd0);

      // Second finish edge during SEND: overrun, no second stream.
      randomize_scores();
      capture();
      stream(0, 1'b1);
      chk("overrun_set", 32'(overrun), 32'd1);
      for (int k = 0; k < 12; k++) begin
         chk("no_second_stream", 32'(out_valid), 32'd0);
         step();
      end

      // Reset mid-stream at index 5.
      randomize_scores();
      capture();
      out_ready = 1'b1;
      waits = 0;
      while (!(out_valid && out_index == 4'd5) && waits < 40) begin
         step();
         waits++;
      end
      chk("reached_index5", 32'(out_index), 32'd5);
      reset = 1'b1;
      finish = 1'b0;
      step();
      chk_all_zero("midreset");
      reset = 1'b0;
      randomize_scores();
      capture();
      stream(2, 1'b0);

      // Random vectors with random backpressure.
      for (int r = 0; r < 4; r++) begin
         randomize_scores();
         capture();
         stream(2, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
